// File: rtl/mul_div_unit.sv
// Multi-cycle signed Booth multiply / restoring divide feeding the Z register.
// Ports: clk, clr (async low), start/op/a_in/b_in in; busy/done/z_load/z_data
// out (z_data = product, or {rem, quot}). Optional MULDIV_DIVZERO_FLAG_EN
// adds a div_zero output and a short-circuit path for division by zero.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic               z_load,
  output logic [2*WIDTH-1:0] z_data
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic               div_zero
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic               sa_q, sb_q, bz_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [WIDTH-1:0]   m_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] z_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic               dz_q;
`endif

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic [WIDTH:0]     m_ext, b_sum;
  logic [WIDTH:0]     rs, trial;
  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   q_d;
  logic               qm1_d;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] res_d;

  // One Booth step (mul) or one restoring step (div).
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    b_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   b_sum = acc_q + m_ext;
      2'b10:   b_sum = acc_q - m_ext;
      default: b_sum = acc_q;
    endcase
    rs    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial = rs - {1'b0, m_q};
    acc_d = acc_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    if (!op_q) begin
      acc_d = {b_sum[WIDTH], b_sum[WIDTH:1]};
      q_d   = {b_sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end else if (!trial[WIDTH]) begin
      acc_d = trial;
      q_d   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rs;
      q_d   = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up of the magnitude divide.
  always_comb begin
    quot  = (sa_q ^ sb_q) ? -q_q : q_q;
    rem   = sa_q ? -acc_q[WIDTH-1:0]
                 : acc_q[WIDTH-1:0];
    res_d = {acc_q[WIDTH-1:0], q_q};
    if (op_q) begin
      if (bz_q) begin
`ifdef MULDIV_DIVZERO_FLAG_EN
        res_d = '0;
`else
        res_d = {a_q, {WIDTH{1'b1}}};
`endif
      end else begin
        res_d = {rem, quot};
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q   <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a_in;
            sa_q    <= a_in[WIDTH-1];
            sb_q    <= b_in[WIDTH-1];
            bz_q    <= (b_in == '0);
            cnt_q   <= '0;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            q_q     <= op ? mag(a_in) : b_in;
            m_q     <= op ? mag(b_in) : a_in;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef MULDIV_DIVZERO_FLAG_EN
            // Zero divisor skips the iterations.
            if (op && b_in == '0) state_q <= FIX;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          z_q     <= res_d;
          done_q  <= 1'b1;
          state_q <= DONE;
`ifdef MULDIV_DIVZERO_FLAG_EN
          dz_q    <= op_q & bz_q;
`endif
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign z_load = done_q;
  assign z_data = z_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases, randoms,
// ignored starts and mid-operation reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, z_load;
  logic [63:0] z_data;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .op(op),
    .a_in(a_in),
    .b_in(b_in),
    .busy(busy),
    .done(done),
    .z_load(z_load),
    .z_data(z_data)
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint pa, pb;
    int sa, sbv, q, r;
    if (!o) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    if (b == 32'd0) begin
`ifdef MULDIV_DIVZERO_FLAG_EN
      return 64'd0;
`else
      return {a, 32'hFFFFFFFF};
`endif
    end
    if (a == 32'h80000000 && b == 32'hFFFFFFFF)
      return {32'd0, 32'h80000000};
    sa  = a;
    sbv = b;
    q = sa / sbv;
    r = sa % sbv;
    return {32'(r), 32'(q)};
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("zload", {63'd0, z_load}, 64'd1);
      chk("sbq", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) chk("zdata", z_data, sb.pop_front());
    end
  end

  task automatic run(input logic o,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [63:0] exp,
                     input int lat);
    int n;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    n = 1;
    chk("busy1", {63'd0, busy}, 64'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("lat", 64'(n), 64'(lat));
`ifdef MULDIV_DIVZERO_FLAG_EN
    chk("dz", {63'd0, div_zero},
        {63'd0, (o && b == 32'd0)});
`endif
    @(negedge clk);
    chk("idle", {63'd0, busy}, 64'd0);
    chk("pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic ro;
    int n, d0, dzl;
    logic [63:0] dze;
`ifdef MULDIV_DIVZERO_FLAG_EN
    dzl = 2;
    dze = 64'd0;
`else
    dzl = 34;
    dze = {32'h00000064, 32'hFFFFFFFF};
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_zl", {63'd0, z_load}, 64'd0);
    chk("rst_z", z_data, 64'd0);
    clr = 1'b1;

    run(1'b0, 32'd7, 32'hFFFFFFFD,
        64'hFFFFFFFF_FFFFFFEB, 34);
    run(1'b0, 32'h80000000, 32'h80000000,
        64'h40000000_00000000, 34);
    run(1'b1, 32'hFFFFFFEF, 32'd5,
        {32'hFFFFFFFE, 32'hFFFFFFFD}, 34);
    run(1'b1, 32'd100, 32'd0, dze, dzl);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF,
        {32'd0, 32'h80000000}, 34);
    run(1'b1, 32'd17, 32'hFFFFFFFB,
        {32'd2, 32'hFFFFFFFD}, 34);
    run(1'b0, 32'h7FFFFFFF, 32'h80000000,
        64'hC0000000_80000000, 34);

    for (int i = 0; i < 12; i++) begin
      ro = 1'($urandom);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 40))
                        : $urandom;
      if (i % 4 == 1) rb = -rb;
      run(ro, ra, rb, model(ro, ra, rb), 34);
    end

    // Starts while busy must be dropped.
    d0 = done_cnt;
    sb.push_back(64'h2A);
    @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    a_in = 32'd6;
    b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 5) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd100;
    b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n++;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 64'(n), 64'd34);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("ign_cnt", 64'(done_cnt), 64'(d0 + 1));
    chk("ign_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of a divide.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd1000;
    b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_done", {63'd0, done}, 64'd0);
    chk("clr_zl", {63'd0, z_load}, 64'd0);
    chk("clr_z", z_data, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (40) @(negedge clk);
    chk("clr_cnt", 64'(done_cnt), 64'(d0));
    run(1'b0, 32'd2, 32'd3, 64'd6, 34);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
